// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   state_t     : arbiter FSM states (IDLE, GRANT)
//   FIFO_DATA_W : width of one FIFO word
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int FIFO_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : fifo_arb_pkg

// File: rtl/fifo_write_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational rotate-priority picker. Searches the request vector starting
// one position after the pointer, wrapping modulo NREQ, and returns the first
// active requester.
//   req_i   : request vector
//   ptr_i   : index of the last owner (search starts at ptr_i + 1)
//   grant_o : one-hot winner (all zero when no request)
//   valid_o : at least one request is active
// -----------------------------------------------------------------------------
module rr_select #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic             valid_o
);

    int idx;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no latch is inferred.
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        // Offsets 1..NREQ visit ptr+1 first and the last owner itself last.
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr_i) + off) % NREQ;
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule : rr_select

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing the single write port of an 8-bit FIFO among
// NREQ producers. One owner at a time holds a grant for up to MAX_BURST words;
// its words are forwarded to the FIFO while it is not full, with a per-word ack.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   req             : requester i presents a valid word
//   req_data        : requester i's word at [8i+7:8i]
//   req_last        : presented word is the last of requester i's burst
//   grant           : registered one-hot owner, zero when idle
//   ack             : one-hot, owner's word accepted this cycle
//   fifo_full       : FIFO full flag
//   fifo_write_en   : FIFO write enable
//   fifo_data       : FIFO write data
//   busy            : a grant is active
//
// Configuration
//   FIFO_ARB_PRIO0_EN : when defined, requester 0 wins every IDLE arbitration
//                       in which it requests, without moving the pointer.
// -----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [FIFO_DATA_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]             req_last,
    output logic [NREQ-1:0]             grant,
    output logic [NREQ-1:0]             ack,
    input  logic                        fifo_full,
    output logic                        fifo_write_en,
    output logic [FIFO_DATA_W-1:0]      fifo_data,
    output logic                        busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state_q;
    logic [NREQ-1:0]    grant_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic [NREQ-1:0]    rr_grant;
    logic               rr_valid;
    logic               prio0;
    logic [NREQ-1:0]    pick_grant;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               accept;
    logic               release_now;

    rr_select #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .valid_o (rr_valid)
    );

`ifdef FIFO_ARB_PRIO0_EN
    assign prio0 = req[0];
`else
    assign prio0 = 1'b0;
`endif

    assign pick_grant = prio0 ? NREQ'(1) : rr_grant;
    assign pick_valid = prio0 | rr_valid;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Write path is combinational from the registered owner so the first word
    // can be accepted in the same cycle the grant appears.
    assign accept        = (state_q == GRANT) && req[owner_q] && !fifo_full;
    assign ack           = accept ? grant_q : '0;
    assign fifo_write_en = accept;
    assign fifo_data     = (state_q == GRANT)
                           ? req_data[owner_q*FIFO_DATA_W +: FIFO_DATA_W]
                           : '0;

    assign beat_d = accept ? beat_q + 1'b1 : beat_q;

    // Last word and burst limit coinciding still gives one release; a dropped
    // request releases even while the FIFO is full.
    assign release_now = (accept && (req_last[owner_q] || beat_d == CNT_W'(MAX_BURST)))
                         || !req[owner_q];

    assign grant = grant_q;
    assign busy  = (state_q == GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= PTR_W'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_grant;
                        owner_q <= pick_idx;
                        beat_q  <= '0;
                        state_q <= GRANT;
                        if (!prio0) begin
                            ptr_q <= pick_idx;
                        end
                    end
                end
                GRANT: begin
                    beat_q <= beat_d;
                    if (release_now) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : fifo_write_arbiter

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter (NREQ=4, MAX_BURST=4, default build).
// Each requester i emits words {i, word_index}; remain[i] is the number of
// words still to send (-1 = endless), last_en[i] enables req_last on the final
// word. Inputs change on the falling edge, outputs are observed 1 ns later.
// Observation vector: {busy, grant, ack, fifo_write_en, fifo_data}.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        fifo_full = 1'b0;
    logic        fifo_write_en;
    logic [7:0]  fifo_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    int remain [4];
    int widx   [4];
    bit last_en[4];

    fifo_write_arbiter #(
        .NREQ      (4),
        .MAX_BURST (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .req_last      (req_last),
        .grant         (grant),
        .ack           (ack),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data     (fifo_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] obs();
        return {busy, grant, ack, fifo_write_en, fifo_data};
    endfunction

    // Expected observation while a grant g is active.
    function automatic logic [17:0] ex(input logic [3:0] g, input logic a, input logic [7:0] d);
        return {1'b1, g, a ? g : 4'b0000, a, d};
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i]            = (remain[i] != 0);
            req_data[i*8 +: 8] = {4'(i), 4'(widx[i])};
            req_last[i]       = last_en[i] && (remain[i] == 1);
        end
    endtask

    // Requesters step to their next word on ack, then move to the next cycle.
    task automatic advance();
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                widx[i]++;
                if (remain[i] > 0) remain[i]--;
            end
        end
        @(negedge clk);
        drive();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            remain[i]  = 0;
            widx[i]    = 0;
            last_en[i] = 1'b0;
        end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (obs() !== 18'h0) begin
                n_err++;
                $display("FAIL reset c%0d: got %h want %h", c, obs(), 18'h0);
            end
            advance();
        end
    endtask

    task automatic test_two_requesters();
        logic [17:0] exp [6] = '{18'h0, ex(4'b0001, 1'b1, 8'h00), ex(4'b0001, 1'b1, 8'h01),
                                 18'h0, ex(4'b0100, 1'b1, 8'h20), 18'h0};
        do_reset();
        remain[0] = 2; last_en[0] = 1'b1;
        remain[2] = 1; last_en[2] = 1'b1;
        drive();
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (obs() !== exp[c]) begin
                n_err++;
                $display("FAIL two_req c%0d: got %h want %h", c, obs(), exp[c]);
            end
            advance();
        end
    endtask

    task automatic test_rotation();
        int writes = 0;
        int acks [4] = '{0, 0, 0, 0};
        logic [17:0] e;
        int o, w;
        do_reset();
        for (int i = 0; i < 4; i++) remain[i] = -1;
        drive();
        for (int c = 0; c < 22; c++) begin
            // Pattern: one idle bubble then four accepted words, owners 0,1,2,3,0.
            o = (c / 5) % 4;
            w = ((c / 5) / 4) * 4 + (c % 5) - 1;
            e = (c % 5 == 0) ? 18'h0 : ex(4'(1 << o), 1'b1, {4'(o), 4'(w)});
            #1;
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL rotation c%0d: got %h want %h", c, obs(), e);
            end
            if (c < 20) begin
                if (fifo_write_en) writes++;
                for (int i = 0; i < 4; i++) if (ack[i]) acks[i]++;
            end
            advance();
        end
        n_cmp++;
        if (writes !== 16) begin
            n_err++;
            $display("FAIL rotation_rate: got %0d writes want 16 in 20 cycles", writes);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (acks[i] !== 4) begin
                n_err++;
                $display("FAIL rotation_acks%0d: got %0d want 4", i, acks[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [17:0] exp [9] = '{18'h0, ex(4'b0001, 1'b1, 8'h00), ex(4'b0001, 1'b1, 8'h01),
                                 ex(4'b0001, 1'b0, 8'h02), ex(4'b0001, 1'b0, 8'h02),
                                 ex(4'b0001, 1'b0, 8'h02), ex(4'b0001, 1'b1, 8'h02),
                                 ex(4'b0001, 1'b1, 8'h03), 18'h0};
        do_reset();
        remain[0] = -1;
        drive();
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            #1;
            n_cmp++;
            if (obs() !== exp[c]) begin
                n_err++;
                $display("FAIL fifo_full c%0d: got %h want %h", c, obs(), exp[c]);
            end
            advance();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_req_drop();
        logic [17:0] exp [9] = '{18'h0, ex(4'b0001, 1'b1, 8'h00), ex(4'b0001, 1'b0, 8'h01),
                                 18'h0, ex(4'b0010, 1'b1, 8'h10), 18'h0,
                                 ex(4'b0100, 1'b1, 8'h20), 18'h0, ex(4'b0001, 1'b1, 8'h01)};
        do_reset();
        remain[0] = 1;
        remain[1] = 1; last_en[1] = 1'b1;
        remain[2] = 1; last_en[2] = 1'b1;
        drive();
        for (int c = 0; c < 9; c++) begin
            #1;
            n_cmp++;
            if (obs() !== exp[c]) begin
                n_err++;
                $display("FAIL req_drop c%0d: got %h want %h", c, obs(), exp[c]);
            end
            // Requester 0 comes back right after its release; the moved pointer
            // must still hand the next grant to requester 1.
            if (c == 2) remain[0] = -1;
            advance();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [17:0] exp [4] = '{18'h0, ex(4'b0001, 1'b1, 8'h00), ex(4'b0001, 1'b1, 8'h01),
                                 ex(4'b0001, 1'b1, 8'h02)};
        do_reset();
        remain[0] = -1;
        drive();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (obs() !== exp[c]) begin
                n_err++;
                $display("FAIL mid_reset c%0d: got %h want %h", c, obs(), exp[c]);
            end
            if (c < 3) advance();
        end
        // Third word on the bus: assert reset between edges.
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 18'h0) begin
            n_err++;
            $display("FAIL mid_reset_async: got %h want %h", obs(), 18'h0);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        remain[0] = 0;
        remain[3] = -1;
        drive();
        #1;
        n_cmp++;
        if (obs() !== 18'h0) begin
            n_err++;
            $display("FAIL mid_reset_idle: got %h want %h", obs(), 18'h0);
        end
        advance();
        #1;
        n_cmp++;
        if (obs() !== ex(4'b1000, 1'b1, 8'h30)) begin
            n_err++;
            $display("FAIL mid_reset_req3: got %h want %h", obs(), ex(4'b1000, 1'b1, 8'h30));
        end
        do_reset();
        remain[0] = -1;
        remain[3] = -1;
        drive();
        #1;
        advance();
        #1;
        n_cmp++;
        if (obs() !== ex(4'b0001, 1'b1, 8'h00)) begin
            n_err++;
            $display("FAIL mid_reset_req03: got %h want %h", obs(), ex(4'b0001, 1'b1, 8'h00));
        end
    endtask

    initial begin
        test_reset();
        test_two_requesters();
        test_rotation();
        test_fifo_full();
        test_req_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_write_arbiter
